pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write enables and bubble-insert (flush) controls for the PC and the fd/dx/xm/mw pipeline latches.
- Resolves three hazard classes: multicycle mult/div occupancy in X, load-use dependencies, and taken branches/jumps resolved in X.
- Holds a mult/div FSM with timeout and a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: mult/div occupancy,
// load-use interlock and X-stage redirect, plus a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      fd_ins,
  input  logic [31:0]      dx_ins,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             xm_we,
  output logic             mw_we,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned TW = $clog2(MD_TIMEOUT) + 1;

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t        state, next_state;
  logic [TW-1:0] tcnt;
  logic          tcnt_clr, tcnt_inc, set_timeout;
  logic          guard, guard_set;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       dx_md, dx_lw, fd_rtype, fd_rd_src, load_use;

  assign fd_op  = fd_ins[31:27];
  assign fd_rd  = fd_ins[26:22];
  assign fd_rs  = fd_ins[21:17];
  assign fd_rt  = fd_ins[16:12];
  assign dx_op  = dx_ins[31:27];
  assign dx_rd  = dx_ins[26:22];
  assign dx_alu = dx_ins[6:2];

  assign dx_md     = (dx_op == 5'b00000) && ((dx_alu == 5'b00110) || (dx_alu == 5'b00111));
  assign dx_lw     = (dx_op == 5'b01000);
  assign fd_rtype  = (fd_op == 5'b00000);
  // sw/bne/blt/jr read their rd field as a source operand
  assign fd_rd_src = (fd_op == 5'b00111) || (fd_op == 5'b00010) ||
                     (fd_op == 5'b00110) || (fd_op == 5'b00100);
  assign load_use  = dx_lw && (dx_rd != 5'd0) &&
                     ((fd_rs == dx_rd) || (fd_rtype && (fd_rt == dx_rd)) ||
                      (fd_rd_src && (fd_rd == dx_rd)));

  assign xm_we   = 1'b1;
  assign mw_we   = 1'b1;
  assign md_busy = (state == MD_BUSY);

  always_comb begin
    pc_we       = 1'b1;
    fd_we       = 1'b1;
    dx_we       = 1'b1;
    fd_flush    = 1'b0;
    dx_flush    = 1'b0;
    xm_flush    = 1'b0;
    md_start    = 1'b0;
    next_state  = state;
    tcnt_clr    = 1'b0;
    tcnt_inc    = 1'b0;
    set_timeout = 1'b0;
    guard_set   = 1'b0;
    if (reset) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (dx_md && !guard) begin
            md_start   = 1'b1;
            pc_we      = 1'b0;
            fd_we      = 1'b0;
            dx_we      = 1'b0;
            xm_flush   = 1'b1;
            tcnt_clr   = 1'b1;
            next_state = MD_BUSY;
          end else if (branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (load_use) begin
            pc_we    = 1'b0;
            fd_we    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_ready) begin
            next_state = IDLE;
            guard_set  = 1'b1;
          end else if (tcnt == TW'(MD_TIMEOUT - 1)) begin
            set_timeout = 1'b1;
            xm_flush    = 1'b1;
            dx_flush    = 1'b1;
            next_state  = IDLE;
            guard_set   = 1'b1;
          end else begin
            pc_we    = 1'b0;
            fd_we    = 1'b0;
            dx_we    = 1'b0;
            xm_flush = 1'b1;
            tcnt_inc = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      md_timeout  <= 1'b0;
      stall_count <= '0;
      guard       <= 1'b0;
    end else begin
      state <= next_state;
      guard <= guard_set;
      if (tcnt_clr)
        tcnt <= '0;
      else if (tcnt_inc)
        tcnt <= tcnt + TW'(1);
      if (set_timeout)
        md_timeout <= 1'b1;
      if (!pc_we && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: decode vector table plus hand-written
// mult/div, timeout, reset-mid-op and counter saturation sequences.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset, branch_taken, md_ready;
  logic [31:0] fd_ins, dx_ins;
  logic        pc_we, fd_we, dx_we, xm_we, mw_we;
  logic        fd_flush, dx_flush, xm_flush, md_start, md_busy, md_timeout;
  logic [31:0] stall_count;

  logic        rst_s;
  logic [31:0] dx_s;
  logic        s_pc_we, s_fd_we, s_dx_we, s_xm_we, s_mw_we;
  logic        s_fd_flush, s_dx_flush, s_xm_flush, s_md_start, s_md_busy, s_md_timeout;
  logic [3:0]  s_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .fd_ins(fd_ins), .dx_ins(dx_ins),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
    .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
    .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(4)) u_sat (
    .clk(clk), .reset(rst_s), .fd_ins(32'd0), .dx_ins(dx_s),
    .branch_taken(1'b0), .md_ready(1'b0),
    .pc_we(s_pc_we), .fd_we(s_fd_we), .dx_we(s_dx_we), .xm_we(s_xm_we), .mw_we(s_mw_we),
    .fd_flush(s_fd_flush), .dx_flush(s_dx_flush), .xm_flush(s_xm_flush),
    .md_start(s_md_start), .md_busy(s_md_busy), .md_timeout(s_md_timeout),
    .stall_count(s_count)
  );

  // {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush, md_start}
  localparam logic [8:0] NORM  = 9'b11111_000_0;
  localparam logic [8:0] LU    = 9'b00111_010_0;
  localparam logic [8:0] BR    = 9'b11111_110_0;
  localparam logic [8:0] START = 9'b00011_001_1;
  localparam logic [8:0] STALL = 9'b00011_001_0;
  localparam logic [8:0] ABORT = 9'b11111_011_0;

  typedef struct {
    logic [31:0] fd;
    logic [31:0] dx;
    logic        br;
    logic        rdy;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [8:0] ctl();
    return {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush, md_start};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic [31:0] NOP, MUL, DIV, LW5, LW0, ADD_RS5;

  initial begin
    NOP     = 32'd0;
    MUL     = ins(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00110);
    DIV     = ins(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00111);
    LW5     = ins(5'b01000, 5'd5, 5'd0, 5'd0, 5'd0);
    LW0     = ins(5'b01000, 5'd0, 5'd0, 5'd0, 5'd0);
    ADD_RS5 = ins(5'b00000, 5'd1, 5'd5, 5'd2, 5'd0);

    vecs[0]  = '{NOP, NOP, 1'b0, 1'b0, NORM};
    vecs[1]  = '{ADD_RS5, LW5, 1'b0, 1'b0, LU};
    vecs[2]  = '{ins(5'b00000, 5'd1, 5'd0, 5'd2, 5'd0), LW0, 1'b0, 1'b0, NORM};
    vecs[3]  = '{ins(5'b00000, 5'd1, 5'd2, 5'd5, 5'd0), LW5, 1'b0, 1'b0, LU};
    vecs[4]  = '{ins(5'b00101, 5'd1, 5'd2, 5'd5, 5'd0), LW5, 1'b0, 1'b0, NORM};
    vecs[5]  = '{ins(5'b00111, 5'd5, 5'd2, 5'd0, 5'd0), LW5, 1'b0, 1'b0, LU};
    vecs[6]  = '{ins(5'b00010, 5'd5, 5'd2, 5'd0, 5'd0), LW5, 1'b0, 1'b0, LU};
    vecs[7]  = '{ins(5'b00110, 5'd5, 5'd2, 5'd0, 5'd0), LW5, 1'b0, 1'b0, LU};
    vecs[8]  = '{ins(5'b00100, 5'd5, 5'd2, 5'd0, 5'd0), LW5, 1'b0, 1'b0, LU};
    vecs[9]  = '{ins(5'b00000, 5'd5, 5'd1, 5'd2, 5'd0), LW5, 1'b0, 1'b0, NORM};
    vecs[10] = '{ADD_RS5, ins(5'b00101, 5'd5, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, NORM};
    vecs[11] = '{ADD_RS5, LW5, 1'b1, 1'b0, BR};
    vecs[12] = '{NOP, NOP, 1'b1, 1'b0, BR};
    vecs[13] = '{NOP, NOP, 1'b0, 1'b1, NORM};
    vecs[14] = '{ins(5'b01000, 5'd7, 5'd5, 5'd0, 5'd0), LW5, 1'b0, 1'b0, LU};

    reset = 1'b1; rst_s = 1'b1; dx_s = MUL;
    fd_ins = NOP; dx_ins = MUL; branch_taken = 1'b0; md_ready = 1'b0;

    // Reset cycle: mul in dx must not start, all enables high
    settle();
    chk("reset_ctl", 32'(ctl()), 32'(NORM));
    cyc(); cyc();
    reset = 1'b0; dx_ins = NOP;
    settle();
    chk("idle_ctl", 32'(ctl()), 32'(NORM));
    chk("idle_cnt", stall_count, 32'd0);
    chk("idle_busy", 32'(md_busy), 32'd0);
    chk("idle_to", 32'(md_timeout), 32'd0);
    cyc();

    // Decode table; seven load-use entries each add one stall cycle
    for (int i = 0; i < 15; i++) begin
      fd_ins = vecs[i].fd; dx_ins = vecs[i].dx;
      branch_taken = vecs[i].br; md_ready = vecs[i].rdy;
      settle();
      chk($sformatf("vec%0d", i), 32'(ctl()), 32'(vecs[i].exp));
      cyc();
    end
    fd_ins = NOP; dx_ins = NOP; branch_taken = 1'b0; md_ready = 1'b0;
    settle();
    chk("table_cnt", stall_count, 32'd7);

    // Branch over load-use leaves the counter alone
    fd_ins = ADD_RS5; dx_ins = LW5; branch_taken = 1'b1;
    settle();
    chk("br_ctl", 32'(ctl()), 32'(BR));
    cyc();
    fd_ins = NOP; dx_ins = NOP; branch_taken = 1'b0;
    settle();
    chk("br_cnt", stall_count, 32'd7);

    // Load-use sequence from reset
    reset = 1'b1; cyc(); reset = 1'b0;
    fd_ins = ADD_RS5; dx_ins = LW5;
    settle();
    chk("lu_ctl", 32'(ctl()), 32'(LU));
    cyc();
    dx_ins = NOP;
    settle();
    chk("lu_after", 32'(ctl()), 32'(NORM));
    chk("lu_cnt", stall_count, 32'd1);
    fd_ins = NOP;

    // Multdiv: start, 5 stalled busy cycles, release on md_ready
    reset = 1'b1; cyc(); reset = 1'b0;
    dx_ins = MUL;
    settle();
    chk("md_start_ctl", 32'(ctl()), 32'(START));
    chk("md_start_busy", 32'(md_busy), 32'd0);
    cyc();
    for (int i = 1; i <= 5; i++) begin
      branch_taken = (i == 2);
      settle();
      chk($sformatf("md_busy_ctl%0d", i), 32'(ctl()), 32'(STALL));
      chk($sformatf("md_busy%0d", i), 32'(md_busy), 32'd1);
      cyc();
    end
    branch_taken = 1'b0;
    md_ready = 1'b1;
    settle();
    chk("md_release", 32'(ctl()), 32'(NORM));
    chk("md_release_busy", 32'(md_busy), 32'd1);
    cyc();
    md_ready = 1'b0;
    settle();
    chk("md_guard", 32'(ctl()), 32'(NORM));
    chk("md_guard_busy", 32'(md_busy), 32'd0);
    chk("md_cnt", stall_count, 32'd6);
    cyc();
    settle();
    chk("md_restart", 32'(ctl()), 32'(START));
    dx_ins = NOP;

    // Timeout: div with no md_ready aborts in the 8th busy cycle
    reset = 1'b1; cyc(); reset = 1'b0;
    dx_ins = DIV;
    settle();
    chk("to_start", 32'(ctl()), 32'(START));
    cyc();
    for (int i = 1; i <= 7; i++) begin
      settle();
      chk($sformatf("to_busy%0d", i), 32'(ctl()), 32'(STALL));
      chk($sformatf("to_flag%0d", i), 32'(md_timeout), 32'd0);
      cyc();
    end
    settle();
    chk("to_abort", 32'(ctl()), 32'(ABORT));
    chk("to_abort_busy", 32'(md_busy), 32'd1);
    cyc();
    settle();
    chk("to_guard", 32'(ctl()), 32'(NORM));
    chk("to_flag", 32'(md_timeout), 32'd1);
    chk("to_idle", 32'(md_busy), 32'd0);
    chk("to_cnt", stall_count, 32'd8);
    dx_ins = NOP;
    repeat (3) cyc();
    settle();
    chk("to_sticky", 32'(md_timeout), 32'd1);

    // Reset during busy cycle 3 (md_timeout still set from the abort)
    dx_ins = MUL;
    settle();
    chk("rm_start", 32'(ctl()), 32'(START));
    cyc(); cyc(); cyc();
    reset = 1'b1;
    settle();
    chk("rm_reset_ctl", 32'(ctl()), 32'(NORM));
    cyc();
    reset = 1'b0; dx_ins = NOP;
    settle();
    chk("rm_busy", 32'(md_busy), 32'd0);
    chk("rm_to", 32'(md_timeout), 32'd0);
    chk("rm_cnt", stall_count, 32'd0);
    chk("rm_ctl", 32'(ctl()), 32'(NORM));

    // Saturation on the 4-bit instance: continuous mul stall from reset
    settle();
    chk("sat_reset", 32'(s_count), 32'd0);
    rst_s = 1'b0;
    repeat (14) cyc();
    settle();
    chk("sat_14", 32'(s_count), 32'd14);
    chk("sat_busy", 32'(s_md_busy), 32'd1);
    repeat (6) cyc();
    settle();
    chk("sat_hold", 32'(s_count), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
